// File: rtl/ycbcr_mcu_sched.sv
// MCU scheduler for YCbCr->RGB conversion: sequences chroma/luma block loads,
// issues one 8x8 conversion at a time and presents results (4:4:4 or 4:2:0).
module ycbcr_mcu_sched #(
   parameter int CONV_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode,
   input  logic       c_valid,
   output logic       c_ready,
   input  logic       y_valid,
   output logic       y_ready,
   output logic       chroma_load,
   output logic       y_load,
   output logic       conv_valid_in,
   output logic [1:0] quad_sel,
   input  logic       conv_valid_out,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_blk_idx,
   output logic       mcu_done,
   output logic       err,
   input  logic       err_clr
);

   localparam int TMR_W = (CONV_TIMEOUT < 1) ? 1 : $clog2(CONV_TIMEOUT + 1);
   // Abort fires on the WAIT_CONV cycle in which the timer reaches CONV_TIMEOUT.
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((CONV_TIMEOUT < 1) ? 0 : CONV_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_Y    = 3'd1,
      S_ISSUE     = 3'd2,
      S_WAIT_CONV = 3'd3,
      S_OUT       = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         blk_idx_q, blk_idx_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               mode_q, mode_d;
   logic               err_q, err_d;
   logic               mcu_done_q, mcu_done_d;
   logic               err_set;
   logic               in_conv_s;
   logic [1:0]         last_idx;

   assign last_idx  = mode_q ? 2'd3 : 2'd0;
   assign in_conv_s = (state_q == S_ISSUE) || (state_q == S_WAIT_CONV) || (state_q == S_OUT);

   // c_ready is masked while rst is high so no handshake can land on a reset cycle.
   assign c_ready       = (state_q == S_IDLE) && !rst;
   assign y_ready       = (state_q == S_WAIT_Y);
   assign chroma_load   = c_ready && c_valid;
   assign y_load        = y_ready && y_valid;
   assign conv_valid_in = (state_q == S_ISSUE);
   assign out_valid     = (state_q == S_OUT);
   assign quad_sel      = (in_conv_s && mode_q) ? blk_idx_q : 2'd0;
   assign out_blk_idx   = (state_q == S_OUT) ? blk_idx_q : 2'd0;
   assign mcu_done      = mcu_done_q;
   assign err           = err_q;

   // Next-state, block index, timer and fault-set logic.
   always_comb begin
      state_d    = state_q;
      blk_idx_d  = blk_idx_q;
      timer_d    = timer_q;
      mode_d     = mode_q;
      mcu_done_d = 1'b0;
      err_set    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (c_valid) begin
               mode_d    = mode;
               blk_idx_d = 2'd0;
               state_d   = S_WAIT_Y;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT_Y: begin
            if (y_valid) begin
               state_d = S_ISSUE;
            end else begin
               state_d = S_WAIT_Y;
            end
         end
         S_ISSUE: begin
            timer_d = '0;
            state_d = S_WAIT_CONV;
         end
         S_WAIT_CONV: begin
            if (conv_valid_out) begin
               state_d = S_OUT;
            end else begin
               timer_d = timer_q + TMR_W'(1);
               if (timer_q >= TMR_LAST) begin
                  err_set   = 1'b1;
                  blk_idx_d = 2'd0;
                  state_d   = S_IDLE;
               end else begin
                  state_d = S_WAIT_CONV;
               end
            end
         end
         S_OUT: begin
            if (out_ready) begin
               if (blk_idx_q == last_idx) begin
                  state_d    = S_IDLE;
                  mcu_done_d = 1'b1;
               end else begin
                  blk_idx_d = blk_idx_q + 2'd1;
                  state_d   = S_WAIT_Y;
               end
            end else begin
               state_d = S_OUT;
            end
         end
         default: begin
            state_d   = S_IDLE;
            blk_idx_d = 2'd0;
         end
      endcase

      // A completion with nothing outstanding is a protocol fault.
      if (conv_valid_out && (state_q != S_WAIT_CONV)) begin
         err_set = 1'b1;
      end else begin
         err_set = err_set;
      end
   end

   // Sticky fault: set wins over clear.
   always_comb begin
      if (err_set) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         blk_idx_q  <= 2'd0;
         timer_q    <= '0;
         mode_q     <= 1'b0;
         err_q      <= 1'b0;
         mcu_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         blk_idx_q  <= blk_idx_d;
         timer_q    <= timer_d;
         mode_q     <= mode_d;
         err_q      <= err_d;
         mcu_done_q <= mcu_done_d;
      end
   end

endmodule
